// File: rtl/stack_top_gen2.sv
// rtl/stack_top_gen2.sv - parametrised return/PSW LIFO stack with status and sticky errors (optional STACK_WRAP_EN)
module stack_top_gen2 #(
    parameter int WIDTH     = 12,
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = 6,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             enable_signal,
    input  logic             PushEnbl,
    input  logic             PopEnbl,
    input  logic             Stack_Clr,
    input  logic             Err_Clr,
    input  logic [WIDTH-1:0] PushDataIn,
    output logic [WIDTH-1:0] PopDataOut,
    output logic [WIDTH-1:0] Top_Data,
    output logic [CNT_W-1:0] Stack_Cnt,
    output logic             STACK_EMPTY,
    output logic             STACK_FULL,
    output logic             STACK_AFULL,
    output logic             STACK_OVF,
    output logic             STACK_UNF
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pop_data_q, pop_data_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             empty, full;
    logic [PTR_W-1:0] wr_idx, top_idx;
    logic [WIDTH-1:0] top_raw;

    logic             mem_we;
    logic [PTR_W-1:0] mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

`ifdef STACK_WRAP_EN
    localparam int SUM_W = CNT_W + 2;

    logic [PTR_W-1:0] base_q, base_d, base_next;
    logic [SUM_W-1:0] wsum, tsum;

    // Circular addressing: write slot is base+count, top is base+count-1, both mod DEPTH
    always_comb begin
        wsum = SUM_W'(base_q) + SUM_W'(cnt_q);
        if (wsum >= SUM_W'(DEPTH)) wsum = wsum - SUM_W'(DEPTH);
        // DEPTH-1 is added instead of subtracting 1 so the sum never goes negative when empty
        tsum = SUM_W'(base_q) + SUM_W'(cnt_q) + SUM_W'(DEPTH - 1);
        if (tsum >= SUM_W'(DEPTH)) tsum = tsum - SUM_W'(DEPTH);
        if (tsum >= SUM_W'(DEPTH)) tsum = tsum - SUM_W'(DEPTH);
        wr_idx    = PTR_W'(wsum);
        top_idx   = PTR_W'(tsum);
        base_next = (base_q == PTR_W'(DEPTH - 1)) ? '0 : base_q + PTR_W'(1);
    end
`else
    // Linear addressing: the stack grows upward from slot 0
    always_comb begin
        wr_idx  = full  ? '0 : PTR_W'(cnt_q);
        top_idx = empty ? '0 : PTR_W'(cnt_q - CNT_W'(1));
    end
`endif

    // Status flags are decoded from the registered occupancy only
    always_comb begin
        empty       = (cnt_q == '0);
        full        = (cnt_q == CNT_W'(DEPTH));
        STACK_EMPTY = empty;
        STACK_FULL  = full;
        STACK_AFULL = (cnt_q >= CNT_W'(AFULL_LVL));
        Stack_Cnt   = cnt_q;
        PopDataOut  = pop_data_q;
        STACK_OVF   = ovf_q;
        STACK_UNF   = unf_q;
        top_raw     = mem[top_idx];
        Top_Data    = empty ? '0 : top_raw;
    end

    // Next-state decode: clear beats push/pop; a fresh error overrides Err_Clr
    always_comb begin
        cnt_d      = cnt_q;
        pop_data_d = pop_data_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        mem_we     = 1'b0;
        mem_waddr  = wr_idx;
        mem_wdata  = PushDataIn;
`ifdef STACK_WRAP_EN
        base_d     = base_q;
`endif
        if (enable_signal) begin
            if (Err_Clr) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
            if (Stack_Clr) begin
                cnt_d = '0;
`ifdef STACK_WRAP_EN
                base_d = '0;
`endif
            end else if (PushEnbl && !PopEnbl) begin
                if (!full) begin
                    mem_we = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                end else begin
`ifdef STACK_WRAP_EN
                    // Overwrite the oldest frame and slide the window up by one
                    mem_we    = 1'b1;
                    mem_waddr = base_q;
                    base_d    = base_next;
`else
                    ovf_d = 1'b1;
`endif
                end
            end else if (PopEnbl && !PushEnbl) begin
                if (!empty) begin
                    pop_data_d = top_raw;
                    cnt_d      = cnt_q - CNT_W'(1);
                end else begin
                    unf_d = 1'b1;
                end
            end else if (PushEnbl && PopEnbl) begin
                if (!empty) begin
                    // Replace-top: old top leaves, new frame takes its slot
                    pop_data_d = top_raw;
                    mem_we     = 1'b1;
                    mem_waddr  = top_idx;
                end else begin
                    pop_data_d = PushDataIn;
                end
            end
        end
        // An edge seen while reset is held must not disturb storage
        if (!Reset) mem_we = 1'b0;
    end

    // Control and status registers with asynchronous active-low reset
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q      <= '0;
            pop_data_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
`ifdef STACK_WRAP_EN
            base_q     <= '0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            pop_data_q <= pop_data_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
`ifdef STACK_WRAP_EN
            base_q     <= base_d;
`endif
        end
    end

    // Frame storage, intentionally not reset
    always_ff @(posedge Clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

endmodule
